// File: rtl/game_pkg.sv
// Shared types and constants for the dice game datapath.
package game_pkg;

  // One second at the 100 MHz system clock; also used by game_logic.
  localparam int unsigned SEC_CYCLES = 100_000_000;

  typedef enum logic [1:0] {
    COLOR_NONE = 2'd0,
    COLOR_1    = 2'd1,
    COLOR_2    = 2'd2,
    COLOR_3    = 2'd3
  } dice_color_t;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMED    = 3'd1,
    S_CONFIRM  = 3'd2,
    S_FIRE     = 3'd3,
    S_LOCKOUT  = 3'd4
  } cap_state_t;

  // Terminal count of the lockout timer; a zero-length lockout is treated as one cycle.
  function automatic int unsigned clr_terminal(input int unsigned cycles);
    return (cycles <= 1) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Saturating clear-interval counter; done flags the last cycle of the lockout window.
module lockout_timer
  import game_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CntW = (CLR_CYCLES < 1) ? 1 : $clog2(CLR_CYCLES + 1);
  localparam int unsigned Term = clr_terminal(CLR_CYCLES);
  localparam logic [CntW-1:0] TermV = CntW'(Term);
  localparam logic [CntW-1:0] MaxV  = '1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear dominates; otherwise count up and stick at all-ones rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxV)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == TermV);

endmodule

// File: rtl/dice_capture_ctrl.sv
// Turns the colour result stream into single dice_valid pulses, one per physical roll.
module dice_capture_ctrl
  import game_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CLR_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm,
  input  logic       result_ready,
  input  logic [1:0] result_color,
  output logic       dice_valid,
  output logic [1:0] dice_value,
  output logic       locked,
  output logic [3:0] match_cnt
);

  localparam logic [3:0] StableV = 4'(STABLE_CNT);

  cap_state_t  state_q, state_d;
  dice_color_t cand_q, cand_d;
  logic [3:0]  match_q, match_d;
  logic        valid_q, valid_d;
  logic [1:0]  value_q, value_d;
  logic        locked_q, locked_d;

  dice_color_t color;
  logic        hit;
  logic        timer_clr;
  logic        timer_en;
  logic        timer_done;

  assign color = dice_color_t'(result_color);
  assign hit   = result_ready && (color != COLOR_NONE);

  // Next-state, candidate/match tracking and lockout timer control.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    match_d   = match_q;
    value_d   = value_q;
    timer_clr = 1'b1;
    unique case (state_q)
      S_DISARMED: begin
        match_d = '0;
        if (arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!arm) begin
          state_d = S_DISARMED;
          match_d = '0;
        end else if (hit) begin
          cand_d  = color;
          match_d = 4'd1;
          if (StableV == 4'd1) begin
            state_d = S_FIRE;
            value_d = result_color;
          end else begin
            state_d = S_CONFIRM;
          end
        end
      end
      S_CONFIRM: begin
        // Disarm beats a result arriving in the same cycle.
        if (!arm) begin
          state_d = S_DISARMED;
          match_d = '0;
        end else if (result_ready) begin
          if (color == COLOR_NONE) begin
            state_d = S_ARMED;
            match_d = '0;
          end else if (color == cand_q) begin
            match_d = match_q + 4'd1;
            if (match_d == StableV) begin
              state_d = S_FIRE;
              value_d = result_color;
            end
          end else begin
            cand_d  = color;
            match_d = 4'd1;
          end
        end
      end
      S_FIRE: begin
        match_d = '0;
        state_d = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        // A die still present restarts the window, even on the terminal cycle.
        timer_clr = hit || timer_done;
        if (!hit && timer_done) state_d = S_DISARMED;
      end
      default: begin
        state_d = S_DISARMED;
        match_d = '0;
      end
    endcase
  end

  assign timer_en = (state_q == S_LOCKOUT);
  assign valid_d  = (state_d == S_FIRE);
  assign locked_d = (state_d == S_FIRE) || (state_d == S_LOCKOUT);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_DISARMED;
      cand_q   <= COLOR_NONE;
      match_q  <= '0;
      valid_q  <= 1'b0;
      value_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      value_q  <= value_d;
      locked_q <= locked_d;
    end
  end

  lockout_timer #(
    .CLR_CYCLES(CLR_CYCLES)
  ) u_lockout_timer (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .done_o (timer_done)
  );

  assign dice_valid = valid_q;
  assign dice_value = value_q;
  assign locked     = locked_q;
  assign match_cnt  = match_q;

endmodule

// File: tb/tb_dice_capture_ctrl.sv
// Directed bench for dice_capture_ctrl with STABLE_CNT=4, CLR_CYCLES=16.
module tb_dice_capture_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       arm = 1'b0;
  logic       result_ready = 1'b0;
  logic [1:0] result_color = 2'd0;
  logic       dice_valid;
  logic [1:0] dice_value;
  logic       locked;
  logic [3:0] match_cnt;

  int compared = 0;
  int mismatched = 0;

  dice_capture_ctrl #(
    .STABLE_CNT(4),
    .CLR_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .result_ready(result_ready),
    .result_color(result_color),
    .dice_valid  (dice_valid),
    .dice_value  (dice_value),
    .locked      (locked),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] c);
    result_ready = 1'b1;
    result_color = c;
    step();
    result_ready = 1'b0;
    result_color = 2'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    arm = 1'b0;
    result_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    compared++;
    if (dice_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %b expected 0", dice_valid); mismatched++;
    end
    compared++;
    if (dice_value !== 2'd0) begin
      $display("FAIL reset_value: got %0d expected 0", dice_value); mismatched++;
    end
    compared++;
    if (locked !== 1'b0) begin
      $display("FAIL reset_locked: got %b expected 0", locked); mismatched++;
    end
    compared++;
    if (match_cnt !== 4'd0) begin
      $display("FAIL reset_match: got %0d expected 0", match_cnt); mismatched++;
    end
    compared++;
    if (dut.state_q !== S_DISARMED) begin
      $display("FAIL reset_state: got %0d expected %0d", dut.state_q, S_DISARMED); mismatched++;
    end
    reset = 1'b0;
  endtask

  // Four spaced strobes of colour 2, then the full lockout window.
  task automatic test_single_roll();
    int n;
    int pulses;
    pulses = 0;
    do_reset();
    arm = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      strobe(2'd2);
      if (i < 3) begin
        compared++;
        if (match_cnt !== 4'(i + 1)) begin
          $display("FAIL roll_match%0d: got %0d expected %0d", i, match_cnt, i + 1); mismatched++;
        end
        if (dice_valid === 1'b1) pulses++;
        repeat (3) begin
          step();
          if (dice_valid === 1'b1) pulses++;
        end
      end
    end
    compared++;
    if (pulses != 0) begin
      $display("FAIL roll_early_pulse: got %0d pulses expected 0", pulses); mismatched++;
    end
    compared++;
    if (dice_valid !== 1'b1) begin
      $display("FAIL roll_pulse: got %b expected 1", dice_valid); mismatched++;
    end
    compared++;
    if (dice_value !== 2'd2) begin
      $display("FAIL roll_value: got %0d expected 2", dice_value); mismatched++;
    end
    n = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (dice_valid === 1'b1) pulses++;
      if (locked !== 1'b1) break;
      n++;
    end
    compared++;
    if (n != 17) begin
      $display("FAIL roll_locked_cycles: got %0d expected 17", n); mismatched++;
    end
    compared++;
    if (pulses != 0) begin
      $display("FAIL roll_second_pulse: got %0d pulses expected 0", pulses); mismatched++;
    end
    compared++;
    if (dut.state_q !== S_DISARMED) begin
      $display("FAIL roll_exit_state: got %0d expected %0d", dut.state_q, S_DISARMED); mismatched++;
    end
    step();
    compared++;
    if (dut.state_q !== S_ARMED) begin
      $display("FAIL roll_rearm: got %0d expected %0d", dut.state_q, S_ARMED); mismatched++;
    end
  endtask

  // Colour change restarts the count: 2,2,3,3,3,3.
  task automatic test_restart();
    logic [1:0] cols [6] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    logic [3:0] exp_m [6] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4};
    do_reset();
    arm = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      strobe(cols[i]);
      compared++;
      if (match_cnt !== exp_m[i]) begin
        $display("FAIL restart_match%0d: got %0d expected %0d", i, match_cnt, exp_m[i]);
        mismatched++;
      end
      compared++;
      if (dice_valid !== (i == 5)) begin
        $display("FAIL restart_valid%0d: got %b expected %b", i, dice_valid, (i == 5));
        mismatched++;
      end
    end
    compared++;
    if (dice_value !== 2'd3) begin
      $display("FAIL restart_value: got %0d expected 3", dice_value); mismatched++;
    end
    step();
    compared++;
    if (dice_valid !== 1'b0 || match_cnt !== 4'd0) begin
      $display("FAIL restart_fire_exit: got valid=%b match=%0d expected valid=0 match=0",
               dice_valid, match_cnt);
      mismatched++;
    end
  endtask

  // A zero result drops back to armed: 1,1,0,1,1,1,1.
  task automatic test_zero_drop();
    logic [1:0] cols [7] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [3:0] exp_m [7] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    do_reset();
    arm = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      strobe(cols[i]);
      compared++;
      if (match_cnt !== exp_m[i]) begin
        $display("FAIL zero_match%0d: got %0d expected %0d", i, match_cnt, exp_m[i]);
        mismatched++;
      end
      compared++;
      if (dice_valid !== (i == 6)) begin
        $display("FAIL zero_valid%0d: got %b expected %b", i, dice_valid, (i == 6));
        mismatched++;
      end
    end
    compared++;
    if (dice_value !== 2'd1) begin
      $display("FAIL zero_value: got %0d expected 1", dice_value); mismatched++;
    end
  endtask

  // Disarm lands together with the confirming strobe.
  task automatic test_disarm();
    int pulses;
    pulses = 0;
    do_reset();
    arm = 1'b1;
    step();
    repeat (3) strobe(2'd2);
    arm = 1'b0;
    strobe(2'd2);
    compared++;
    if (dice_valid !== 1'b0) begin
      $display("FAIL disarm_valid: got %b expected 0", dice_valid); mismatched++;
    end
    compared++;
    if (dut.state_q !== S_DISARMED) begin
      $display("FAIL disarm_state: got %0d expected %0d", dut.state_q, S_DISARMED); mismatched++;
    end
    compared++;
    if (match_cnt !== 4'd0 || locked !== 1'b0) begin
      $display("FAIL disarm_match: got match=%0d locked=%b expected match=0 locked=0",
               match_cnt, locked);
      mismatched++;
    end
    repeat (3) begin
      step();
      if (dice_valid === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      $display("FAIL disarm_late_pulse: got %0d pulses expected 0", pulses); mismatched++;
    end
  endtask

  // Die left in place keeps the lockout alive; removal releases it after 16 cycles.
  task automatic test_back_to_back();
    int pulses;
    int bad_lock;
    int since;
    pulses = 0;
    bad_lock = 0;
    since = 0;
    do_reset();
    arm = 1'b1;
    step();
    repeat (4) strobe(2'd1);
    compared++;
    if (dice_valid !== 1'b1 || dice_value !== 2'd1) begin
      $display("FAIL b2b_first_pulse: got valid=%b value=%0d expected valid=1 value=1",
               dice_valid, dice_value);
      mismatched++;
    end
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) begin
        result_ready = 1'b1;
        result_color = 2'd3;
      end
      step();
      result_ready = 1'b0;
      result_color = 2'd0;
      if (i % 10 == 0) since = 0;
      else since++;
      if (dice_valid === 1'b1) pulses++;
      if (locked !== 1'b1) bad_lock++;
    end
    compared++;
    if (pulses != 0) begin
      $display("FAIL b2b_second_pulse: got %0d pulses expected 0", pulses); mismatched++;
    end
    compared++;
    if (bad_lock != 0) begin
      $display("FAIL b2b_locked_held: got %0d unlocked cycles expected 0", bad_lock);
      mismatched++;
    end
    for (int k = 0; k < 40; k++) begin
      if (locked !== 1'b1) break;
      step();
      since++;
    end
    compared++;
    if (since != 16) begin
      $display("FAIL b2b_release: got %0d cycles expected 16", since); mismatched++;
    end
    step();
    compared++;
    if (dut.state_q !== S_ARMED) begin
      $display("FAIL b2b_rearm: got %0d expected %0d", dut.state_q, S_ARMED); mismatched++;
    end
  endtask

  // Reset on the confirming strobe cancels the pulse; continues from the armed state above.
  task automatic test_reset_mid();
    repeat (3) strobe(2'd3);
    reset = 1'b1;
    strobe(2'd3);
    compared++;
    if (dice_valid !== 1'b0) begin
      $display("FAIL mid_valid: got %b expected 0", dice_valid); mismatched++;
    end
    compared++;
    if (dice_value !== 2'd0) begin
      $display("FAIL mid_value: got %0d expected 0", dice_value); mismatched++;
    end
    compared++;
    if (locked !== 1'b0 || match_cnt !== 4'd0) begin
      $display("FAIL mid_locked_match: got locked=%b match=%0d expected 0/0", locked, match_cnt);
      mismatched++;
    end
    compared++;
    if (dut.state_q !== S_DISARMED) begin
      $display("FAIL mid_state: got %0d expected %0d", dut.state_q, S_DISARMED); mismatched++;
    end
    reset = 1'b0;
    step();
    compared++;
    if (dice_valid !== 1'b0 || dut.state_q !== S_ARMED) begin
      $display("FAIL mid_after: got valid=%b state=%0d expected valid=0 state=%0d",
               dice_valid, dut.state_q, S_ARMED);
      mismatched++;
    end
  endtask

  initial begin
    test_reset();
    test_single_roll();
    test_restart();
    test_zero_drop();
    test_disarm();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dice_capture_ctrl.md
Name: dice_capture_ctrl

Overview:
Sequences the colour-detection result stream into clean dice events for the game FSM.
- Accepts results only while the game is waiting for a roll (arm high).
- Requires STABLE_CNT consecutive identical non-zero colours before emitting a single-cycle dice_valid pulse.
- After a pulse, locks out until the die has been removed for CLR_CYCLES, so one physical roll never produces two moves.
- Sits between the colour result manager and game_logic.

Parameters:
STABLE_CNT, 4, consecutive matching non-zero results required to confirm a roll (legal range 1..15)
CLR_CYCLES, 50_000_000, clock cycles without a non-zero result required to leave lockout (0.5 s at 100 MHz; bench uses 16)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
arm  in  1  level; high while game_logic is in its wait-for-dice state
result_ready  in  1  one-cycle strobe from the colour result manager
result_color  in  2  colour code, valid with result_ready; 0 = no die, 1..3 = die value
dice_valid  out  1  one-cycle pulse; a confirmed roll
dice_value  out  2  confirmed value; held until the next pulse
locked  out  1  high in FIRE and LOCKOUT
match_cnt  out  4  current consecutive-match count (debug)

Behaviour:
- Clock and reset: single clock; synchronous active-high reset; all outputs and state are registered.
- Reset values: state=S_DISARMED, dice_valid=0, dice_value=0, locked=0, match_cnt=0, cand=0, clr_cnt=0.
- Reset mid-operation: returns to S_DISARMED on the next edge. A pending FIRE is dropped and no pulse is emitted.
- States: S_DISARMED, S_ARMED, S_CONFIRM, S_FIRE, S_LOCKOUT.
- S_DISARMED:
  - result_ready is ignored and match_cnt is cleared.
  - arm=1 -> S_ARMED on the next edge (1-cycle arming latency).
- S_ARMED:
  - arm=0 -> S_DISARMED.
  - Else result_ready with colour≠0 -> cand=colour, match_cnt=1. Next state is S_CONFIRM, or S_FIRE directly if STABLE_CNT==1.
  - colour=0 results are ignored.
- S_CONFIRM (arm=0 has priority over a same-cycle result -> S_DISARMED, match_cnt=0):
  - result_ready, colour==cand: match_cnt+1. If the new count equals STABLE_CNT -> S_FIRE.
  - result_ready, colour≠cand and ≠0: cand=colour, match_cnt=1 (restart).
  - result_ready, colour=0: match_cnt=0 -> S_ARMED.
  - No strobe: hold.
- Entry to S_FIRE: registered on the same edge that samples the confirming result.
  - dice_valid=1, dice_value=cand.
  - Pulse therefore appears 1 cycle after the confirming result_ready cycle.
- S_FIRE: exactly one cycle. dice_valid returns to 0, match_cnt=0, clr_cnt=0 -> S_LOCKOUT, unconditionally (arm is ignored).
- S_LOCKOUT:
  - arm and colours are ignored for confirmation.
  - Any result_ready with colour≠0 -> clr_cnt=0. Otherwise clr_cnt increments every cycle.
  - clr_cnt==CLR_CYCLES-1 -> S_DISARMED with clr_cnt=0. CLR_CYCLES=0 behaves as 1.
  - A clearing result and a terminal count in the same cycle: the clear wins and the counter restarts.
- Widths: clr_cnt is $clog2(CLR_CYCLES+1) bits and saturates, never wraps. match_cnt is 4 bits and never exceeds STABLE_CNT.
- dice_value stays stable outside the FIRE entry edge. game_logic samples it together with dice_valid.

Decomposition:
- Package game_pkg:
  - dice_color_t enum: COLOR_NONE=0, COLOR_1=1, COLOR_2=2, COLOR_3=3.
  - cap_state_t enum for the five states.
  - SEC_CYCLES=100_000_000 constant, shared with game_logic.
- One natural sub-module, lockout_timer: saturating counter with clear, enable and done; parameter CLR_CYCLES. The FSM and match counter stay inline.

Test Plan:
(Bench uses STABLE_CNT=4, CLR_CYCLES=16.)
1. arm=1; four strobes colour=2, 3 idle cycles apart -> exactly one dice_valid pulse, 1 cycle after the 4th strobe; dice_value=2; locked=1 for ≥17 cycles.
2. arm=1; strobes 2,2,3,3,3,3 -> match_cnt sequence 1,2,1,2,3,4; one pulse with dice_value=3.
3. arm=1; strobes 1,1,0,1,1,1,1 -> match_cnt drops to 0 after the 0; pulse after the 7th strobe only; dice_value=1.
4. arm=1; 3 matching strobes, then arm=0 in the same cycle as the 4th strobe -> no pulse; state S_DISARMED; match_cnt=0.
5. After a pulse, colour=3 strobe every 10 cycles for 100 cycles with arm=1 -> no second pulse and locked stays 1. Strobes stop -> locked falls 16 cycles after the last strobe; S_ARMED follows 1 cycle later (arm still high).
6. Assert reset in the cycle the 4th matching strobe arrives -> dice_valid stays 0; all outputs hold their reset values on the next edge.
